// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush sequencer for the in-order RV32IM pipeline
// (fetch -> decode -> exec -> mem/wb).
//
// It produces one load-enable strobe per stage register. It also inserts a
// decode bubble on a load-use hazard and flushes fetch/decode after a redirect
// resolved in exec. It freezes the pipe while a multi-cycle mul/div is in exec
// or while data memory is busy. It keeps saturating stall/flush counters.
//
// Enable semantics: a stage register captures its input only in a cycle where
// its *_enabled strobe is 1; otherwise it holds. There is no back-pressure
// beyond these strobes. dec_valid qualifies dec_is_load/dec_rd_addr. When
// bubble=1 in a cycle where decode_enabled=1, decode loads a NOP instead of
// the fetched word.
//
// Parameters
//   FLUSH_CYCLES  bubble cycles (including the redirect cycle) per redirect, 1..7
//   CNT_W         width of the performance counters
//
// Ports
//   clk, rstn                         clock, async active-low reset
//   id_rs1_addr, id_rs2_addr          source regs of the instruction in decode
//   dec_valid, dec_is_load,
//   dec_rd_addr                       instruction held in the decode output reg
//   ex_is_muldiv, muldiv_done         multi-cycle op in exec / its completion
//   ex_redirect                       exec resolved a control transfer
//   mem_busy                          data memory wait state
//   fetch/decode/exec/mem_enabled     per-stage load strobes
//   bubble                            decode loads a NOP
//   flush                             fetch drops in-flight word, follows target
//   stall_count, flush_count          saturating performance counters
//   state                             debug view of the sequencer state
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             dec_valid,
   input  logic             dec_is_load,
   input  logic [4:0]       dec_rd_addr,
   input  logic             ex_is_muldiv,
   input  logic             muldiv_done,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             fetch_enabled,
   output logic             decode_enabled,
   output logic             exec_enabled,
   output logic             mem_enabled,
   output logic             bubble,
   output logic             flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      ST_BOOT       = 3'd0,
      ST_RUN        = 3'd1,
      ST_LOAD_STALL = 3'd2,
      ST_MD_WAIT    = 3'd3,
      ST_MEM_WAIT   = 3'd4,
      ST_FLUSH      = 3'd5
   } state_t;

   // Remaining FLUSH-state cycles after the redirect cycle itself.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       fcnt_q;
   logic [2:0]       fcnt_d;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Raw (ungated) controls from the next-state logic.
   logic fetch_en;
   logic decode_en;
   logic exec_en;
   logic mem_en;
   logic bubble_raw;
   logic flush_raw;
   logic redirect_taken;
   logic load_use;

   // A real load in decode whose destination is read by the instruction now
   // being decoded. x0 never creates a dependency.
   assign load_use = dec_valid && dec_is_load && (dec_rd_addr != 5'd0) &&
                     ((dec_rd_addr == id_rs1_addr) || (dec_rd_addr == id_rs2_addr));

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_BOOT;
         fcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and strobe logic
   // ---------------------------------------------------------------------------
   always_comb begin
      fetch_en       = 1'b0;
      decode_en      = 1'b0;
      exec_en        = 1'b0;
      mem_en         = 1'b0;
      bubble_raw     = 1'b0;
      flush_raw      = 1'b0;
      redirect_taken = 1'b0;
      state_d        = state_q;
      fcnt_d         = fcnt_q;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end

         // MEM_WAIT shares the RUN decision once memory frees up. Exec was
         // frozen, so a redirect it raised while memory was busy is still
         // present and is taken here. The load-use check is masked only in
         // LOAD_STALL, where decode already holds the inserted bubble.
         ST_RUN, ST_LOAD_STALL, ST_MEM_WAIT: begin
            if (mem_busy) begin
               state_d = ST_MEM_WAIT;
            end else if (ex_redirect) begin
               fetch_en       = 1'b1;
               decode_en      = 1'b1;
               exec_en        = 1'b1;
               mem_en         = 1'b1;
               bubble_raw     = 1'b1;
               flush_raw      = 1'b1;
               redirect_taken = 1'b1;
               fcnt_d         = FLUSH_RELOAD;
               state_d        = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
            end else if (ex_is_muldiv && !muldiv_done) begin
               // Exec holds the op; mem drains whatever is ahead of it.
               mem_en  = 1'b1;
               state_d = ST_MD_WAIT;
            end else if (load_use && (state_q != ST_LOAD_STALL)) begin
               // Load moves on to exec; the dependent instruction is held in
               // fetch/decode input while decode loads a NOP.
               decode_en  = 1'b1;
               exec_en    = 1'b1;
               mem_en     = 1'b1;
               bubble_raw = 1'b1;
               state_d    = ST_LOAD_STALL;
            end else begin
               fetch_en  = 1'b1;
               decode_en = 1'b1;
               exec_en   = 1'b1;
               mem_en    = 1'b1;
               state_d   = ST_RUN;
            end
         end

         // Redirects are ignored here: exec is busy with the mul/div op and
         // cannot have resolved a branch.
         ST_MD_WAIT: begin
            mem_en = !mem_busy;
            if (muldiv_done && !mem_busy) begin
               fetch_en  = 1'b1;
               decode_en = 1'b1;
               exec_en   = 1'b1;
               state_d   = ST_RUN;
            end
         end

         // Bubbles keep flowing; a busy memory freezes the pipe and the count.
         // Exec only holds bubbles, so a redirect here cannot be genuine.
         ST_FLUSH: begin
            bubble_raw = 1'b1;
            flush_raw  = 1'b1;
            if (!mem_busy) begin
               fetch_en  = 1'b1;
               decode_en = 1'b1;
               exec_en   = 1'b1;
               mem_en    = 1'b1;
               fcnt_d    = fcnt_q - 3'd1;
               if (fcnt_q <= 3'd1) begin
                  state_d = ST_RUN;
               end
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Performance counters (saturating)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!fetch_en && (state_q != ST_BOOT) && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (redirect_taken && (flush_q != '1)) begin
            flush_q <= flush_q + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. Strobes are gated by rstn so they drop the moment reset asserts,
   // independent of the clock.
   // ---------------------------------------------------------------------------
   assign fetch_enabled  = rstn & fetch_en;
   assign decode_enabled = rstn & decode_en;
   assign exec_enabled   = rstn & exec_en;
   assign mem_enabled    = rstn & mem_en;
   assign bubble         = rstn & bubble_raw;
   assign flush          = rstn & flush_raw;
   assign stall_count    = stall_q;
   assign flush_count    = flush_q;
   assign state          = state_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the in-order RV32IM pipeline (fetch → decode → exec → mem/wb). It generates the per-stage `enabled` strobes consumed by fetch, decode, exec and mem. It detects load-use hazards from decode's rs1/rs2 address outputs and sequences redirect flushes from exec. It also holds the pipe for multi-cycle mul/div and data-memory wait states, and keeps saturating stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 2, number of bubble cycles inserted after an accepted redirect (1..7)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rstn  in  1  reset, asynchronous, active-low
id_rs1_addr  in  5  rs1 address driven by decode for the instruction being decoded (0 if unused)
id_rs2_addr  in  5  rs2 address driven by decode (0 if unused)
dec_valid  in  1  decode output register holds a real instruction
dec_is_load  in  1  that instruction is a load
dec_rd_addr  in  5  its rd address
ex_is_muldiv  in  1  exec holds a multi-cycle mul/div/rem op
muldiv_done  in  1  mul/div result valid this cycle
ex_redirect  in  1  exec resolved taken branch/jal/jalr/trap/mret this cycle
mem_busy  in  1  data memory cannot accept/complete this cycle
fetch_enabled  out  1  fetch advances
decode_enabled  out  1  decode register loads
exec_enabled  out  1  exec register loads
mem_enabled  out  1  mem/wb register loads
bubble  out  1  decode loads NOP (all flags 0, dec_valid 0) instead of fetched word
flush  out  1  fetch discards in-flight word, follows redirect target
stall_count  out  CNT_W  cycles with fetch_enabled=0 outside BOOT, saturating
flush_count  out  CNT_W  accepted redirects, saturating
state  out  3  debug: BOOT=0 RUN=1 LOAD_STALL=2 MD_WAIT=3 MEM_WAIT=4 FLUSH=5

Behaviour:
- Reset (async, rstn=0): state=BOOT, flush counter=0, stall_count=0, flush_count=0. All strobes, bubble and flush are forced 0 combinationally while rstn=0. Reset mid-operation aborts any stall/flush immediately.
- State and counters are registered. Strobes are combinational from state and inputs, so control takes effect in the same cycle.
- BOOT: all strobes 0 for exactly one cycle, then → RUN.
- RUN / LOAD_STALL decision, first match wins:
  1. mem_busy: all strobes 0 → MEM_WAIT.
  2. ex_redirect: all strobes 1, flush=1, bubble=1, flush_count++, cycle counter loaded with FLUSH_CYCLES-1; → FLUSH, or → RUN directly if FLUSH_CYCLES=1.
  3. ex_is_muldiv & !muldiv_done: fetch/decode/exec 0, mem 1 (bubble into mem) → MD_WAIT.
  4. Load-use hazard: state=RUN & dec_valid & dec_is_load & dec_rd_addr≠0 & (dec_rd_addr==id_rs1_addr | dec_rd_addr==id_rs2_addr). Response: fetch 0, decode 1 with bubble=1, exec 1, mem 1 → LOAD_STALL. Rule 4 is masked in LOAD_STALL, so one hazard gives exactly one bubble.
  5. Otherwise: all strobes 1 → RUN.
- MD_WAIT: fetch/decode/exec 0. mem follows !mem_busy. ex_redirect is ignored. When muldiv_done=1 and mem_busy=0, all strobes are 1 → RUN.
- MEM_WAIT: all strobes 0 while mem_busy. In the first cycle with mem_busy=0, apply the RUN rules to current inputs. Exec was held, so a pending ex_redirect is still asserted and is honoured then.
- FLUSH: flush=1, bubble=1, all strobes 1; counter decrements; counter==0 → RUN.
  - mem_busy in FLUSH: all strobes 0, flush/bubble stay 1, counter frozen.
  - ex_redirect in FLUSH: ignored (exec holds only bubbles).
- stall_count increments in every cycle where fetch_enabled=0 and state≠BOOT. Both counters saturate at all-ones.
- Illegal state encodings → BOOT on the next clock.

Test Plan:
- Reset release → BOOT 1 cycle (all strobes 0, state=0), then RUN with all strobes 1; stall_count=0.
- dec_valid=1, dec_is_load=1, dec_rd_addr=5, id_rs2_addr=5 → one cycle fetch=0, bubble=1, state=2, then RUN; stall_count=1. Same stimulus with dec_rd_addr=0 → no stall.
- ex_redirect pulse with FLUSH_CYCLES=2 → flush=1 and bubble=1 for exactly 2 cycles, flush_count=1. With FLUSH_CYCLES=1 → 1 cycle, straight to RUN.
- ex_is_muldiv=1, muldiv_done raised after 33 cycles → fetch/decode/exec low for 33 cycles, mem high; released in the done cycle; stall_count=33.
- mem_busy=1 together with ex_redirect=1 for 3 cycles → all strobes 0 for 3 cycles, no flush. On release the redirect is taken: flush for FLUSH_CYCLES cycles, flush_count=1.
- rstn pulled low mid-FLUSH and mid-MD_WAIT → strobes 0 asynchronously, counters cleared, BOOT sequence on release. Preset counters to all-ones → no wrap.
